// File: rtl/cache_op_engine.sv
// MIPS CACHE maintenance engine for one 2-way set-associative cache.
// It sequences tag read/check, optional dirty-line writeback, and tag write, then pulses done.
module cache_op_engine #(
    parameter int INDEX_W   = 8,
    parameter int TAG_W     = 20,
    parameter int LINE_W    = 128,
    parameter int HAS_DIRTY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               req_way,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               req_valid_bit,
    input  logic               req_dirty_bit,
    output logic               busy,
    output logic               done,
    output logic               tag_rd_en,
    output logic [INDEX_W-1:0] tag_addr,
    input  logic [TAG_W+1:0]   tag_rdata0,
    input  logic [TAG_W+1:0]   tag_rdata1,
    output logic [1:0]         tag_we,
    output logic [TAG_W+1:0]   tag_wdata,
    output logic               data_rd_en,
    output logic               data_rd_way,
    output logic [INDEX_W-1:0] data_rd_index,
    input  logic [LINE_W-1:0]  data_rdata,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [31:0]        wb_addr,
    output logic [LINE_W-1:0]  wb_data
);

    localparam logic [2:0] OP_IDX_INV   = 3'd0;
    localparam logic [2:0] OP_IDX_STORE = 3'd1;
    localparam logic [2:0] OP_IDX_WBINV = 3'd2;
    localparam logic [2:0] OP_HIT_INV   = 3'd3;
    localparam logic [2:0] OP_HIT_WBINV = 3'd4;
    localparam logic       DIRTY_EN     = (HAS_DIRTY != 0);

    typedef enum logic [2:0] {
        IDLE, TAG_RD, TAG_CHK, DATA_RD, DATA_LAT, WB_SEND, TAG_WR, DONE
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [INDEX_W-1:0] index_q;
    logic               way_q;
    logic [TAG_W-1:0]   tag_q;
    logic               vic_way;
    logic [TAG_W-1:0]   vic_tag;

    logic               hit0, hit1, hit_op, wb_op;
    logic               chk_go, chk_way, chk_dirty;
    logic [TAG_W+1:0]   chk_entry;

    function automatic logic [1:0] way_sel(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Victim choice: Index ops take the requested way, Hit ops the matching way (way0 first).
    always_comb begin
        hit_op    = (op_q == OP_HIT_INV) || (op_q == OP_HIT_WBINV);
        wb_op     = (op_q == OP_IDX_WBINV) || (op_q == OP_HIT_WBINV);
        hit0      = tag_rdata0[TAG_W+1] && (tag_rdata0[TAG_W-1:0] == tag_q);
        hit1      = tag_rdata1[TAG_W+1] && (tag_rdata1[TAG_W-1:0] == tag_q);
        chk_go    = 1'b1;
        chk_way   = way_q;
        if (hit_op) begin
            chk_go  = hit0 || hit1;
            chk_way = !hit0;
        end
        chk_entry = chk_way ? tag_rdata1 : tag_rdata0;
        chk_dirty = DIRTY_EN && wb_op && chk_entry[TAG_W+1] && chk_entry[TAG_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            tag_rd_en  <= 1'b0;
            tag_we     <= '0;
            tag_wdata  <= '0;
            data_rd_en <= 1'b0;
            wb_valid   <= 1'b0;
        end else begin
            done       <= 1'b0;
            tag_rd_en  <= 1'b0;
            tag_we     <= '0;
            data_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        index_q <= req_index;
                        way_q   <= req_way;
                        tag_q   <= req_tag;
                        case (req_op)
                            OP_IDX_INV: begin
                                tag_we    <= way_sel(req_way);
                                tag_wdata <= '0;
                                state     <= TAG_WR;
                            end
                            OP_IDX_STORE: begin
                                tag_we    <= way_sel(req_way);
                                tag_wdata <= {req_valid_bit, req_dirty_bit & DIRTY_EN, req_tag};
                                state     <= TAG_WR;
                            end
                            OP_IDX_WBINV, OP_HIT_INV, OP_HIT_WBINV: begin
                                tag_rd_en <= 1'b1;
                                state     <= TAG_RD;
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        endcase
                    end
                end
                TAG_RD: state <= TAG_CHK;
                TAG_CHK: begin
                    if (!chk_go) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        vic_way <= chk_way;
                        vic_tag <= chk_entry[TAG_W-1:0];
                        if (chk_dirty) begin
                            data_rd_en <= 1'b1;
                            state      <= DATA_RD;
                        end else begin
                            tag_we    <= way_sel(chk_way);
                            tag_wdata <= '0;
                            state     <= TAG_WR;
                        end
                    end
                end
                DATA_RD: state <= DATA_LAT;
                DATA_LAT: begin
                    wb_data  <= data_rdata;
                    wb_valid <= 1'b1;
                    state    <= WB_SEND;
                end
                WB_SEND: begin
                    if (wb_ready) begin
                        wb_valid  <= 1'b0;
                        tag_we    <= way_sel(vic_way);
                        tag_wdata <= '0;
                        state     <= TAG_WR;
                    end
                end
                TAG_WR: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign tag_addr      = index_q;
    assign data_rd_index = index_q;
    assign data_rd_way   = vic_way;
    assign wb_addr       = 32'({vic_tag, index_q, 4'b0000});

endmodule

// File: tb/tb_cache_op_engine.sv
// Directed, table-driven bench for cache_op_engine: one HAS_DIRTY=1 and one HAS_DIRTY=0 instance.
// The bench models the tag/data arrays with one-cycle read latency.
module tb_cache_op_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, req_valid, req_valid_nd, req_way, req_valid_bit, req_dirty_bit, wb_ready;
    logic [2:0]   req_op;
    logic [7:0]   req_index;
    logic [19:0]  req_tag;
    logic [21:0]  tag_rdata0, tag_rdata1, ent0, ent1;
    logic [127:0] data_rdata;
    logic [127:0] line_pat = 128'h1111_1111_2222_2222_3333_3333_4444_4444;

    logic         m_ready, m_busy, m_done, m_trd, m_drd, m_dway, m_wbv;
    logic [7:0]   m_taddr, m_didx;
    logic [1:0]   m_we;
    logic [21:0]  m_wd;
    logic [31:0]  m_wba;
    logic [127:0] m_wbd;
    logic         n_ready, n_busy, n_done, n_trd, n_drd, n_dway, n_wbv;
    logic [7:0]   n_taddr, n_didx;
    logic [1:0]   n_we;
    logic [21:0]  n_wd;
    logic [31:0]  n_wba;
    logic [127:0] n_wbd;

    cache_op_engine #(.INDEX_W(8), .TAG_W(20), .LINE_W(128), .HAS_DIRTY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(m_ready), .req_op(req_op),
        .req_index(req_index), .req_way(req_way), .req_tag(req_tag), .req_valid_bit(req_valid_bit),
        .req_dirty_bit(req_dirty_bit), .busy(m_busy), .done(m_done), .tag_rd_en(m_trd),
        .tag_addr(m_taddr), .tag_rdata0(tag_rdata0), .tag_rdata1(tag_rdata1), .tag_we(m_we),
        .tag_wdata(m_wd), .data_rd_en(m_drd), .data_rd_way(m_dway), .data_rd_index(m_didx),
        .data_rdata(data_rdata), .wb_valid(m_wbv), .wb_ready(wb_ready), .wb_addr(m_wba), .wb_data(m_wbd)
    );

    cache_op_engine #(.INDEX_W(8), .TAG_W(20), .LINE_W(128), .HAS_DIRTY(0)) dut_nd (
        .clk(clk), .reset(reset), .req_valid(req_valid_nd), .req_ready(n_ready), .req_op(req_op),
        .req_index(req_index), .req_way(req_way), .req_tag(req_tag), .req_valid_bit(req_valid_bit),
        .req_dirty_bit(req_dirty_bit), .busy(n_busy), .done(n_done), .tag_rd_en(n_trd),
        .tag_addr(n_taddr), .tag_rdata0(tag_rdata0), .tag_rdata1(tag_rdata1), .tag_we(n_we),
        .tag_wdata(n_wd), .data_rd_en(n_drd), .data_rd_way(n_dway), .data_rd_index(n_didx),
        .data_rdata(data_rdata), .wb_valid(n_wbv), .wb_ready(wb_ready), .wb_addr(n_wba), .wb_data(n_wbd)
    );

    // Arrays return garbage except in the cycle after a read strobe.
    always @(posedge clk) begin
        tag_rdata0 <= (m_trd | n_trd) ? ent0 : '1;
        tag_rdata1 <= (m_trd | n_trd) ? ent1 : '1;
        data_rdata <= (m_drd | n_drd) ? line_pat : ~line_pat;
    end

    logic         sel_nd;
    logic         s_ready, s_busy, s_done, s_trd, s_drd, s_wbv;
    logic [7:0]   s_taddr, s_didx;
    logic [1:0]   s_we;
    logic [21:0]  s_wd;
    logic [31:0]  s_wba;
    logic [127:0] s_wbd;
    always_comb begin
        s_ready = sel_nd ? n_ready : m_ready;
        s_busy  = sel_nd ? n_busy  : m_busy;
        s_done  = sel_nd ? n_done  : m_done;
        s_trd   = sel_nd ? n_trd   : m_trd;
        s_drd   = sel_nd ? n_drd   : m_drd;
        s_wbv   = sel_nd ? n_wbv   : m_wbv;
        s_taddr = sel_nd ? n_taddr : m_taddr;
        s_didx  = sel_nd ? n_didx  : m_didx;
        s_we    = sel_nd ? n_we    : m_we;
        s_wd    = sel_nd ? n_wd    : m_wd;
        s_wba   = sel_nd ? n_wba   : m_wba;
        s_wbd   = sel_nd ? n_wbd   : m_wbd;
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int vi, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, vi, act, exp);
        end
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  idx;
        logic        way;
        logic [19:0] tag;
        logic        vb, db;
        logic [21:0] e0, e1;
        int          wbr;      // first cycle (after accept) with wb_ready high
        logic        nd;       // run on the HAS_DIRTY=0 instance
        logic [1:0]  x_we;
        int          x_wecyc;
        logic [21:0] x_wd;
        int          x_done;
        int          x_rd;
        int          x_wbv;
        logic [31:0] x_addr;
    } vec_t;

    vec_t vecs[14];

    task automatic run_vec(input vec_t v, input int vi);
        int we_cnt = 0, we_cyc = 0, done_cnt = 0, done_cyc = 0, drd_cyc = 0, wbv_cnt = 0;
        logic [1:0]   we_val = '0;
        logic [21:0]  wd = '0;
        logic [31:0]  wba = '0;
        logic [127:0] wbd = '0;
        logic         stable = 1'b1, addr_ok = 1'b1, rdy_after = 1'b0;
        @(negedge clk);
        sel_nd = v.nd;
        ent0 = v.e0; ent1 = v.e1;
        req_op = v.op; req_index = v.idx; req_way = v.way; req_tag = v.tag;
        req_valid_bit = v.vb; req_dirty_bit = v.db;
        req_valid = !v.nd; req_valid_nd = v.nd;
        wb_ready = (v.wbr <= 0);
        #1 chk("ready_at_accept", vi, 64'(s_ready), 64'(1));
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_valid_nd = 1'b0;
            if (s_we != 2'b00) begin we_cnt++; we_cyc = c; we_val = s_we; wd = s_wd; end
            if (done_cyc != 0 && c == done_cyc + 1) rdy_after = s_ready;
            if (s_done) begin done_cnt++; done_cyc = c; end
            if (s_trd && s_taddr != v.idx) addr_ok = 1'b0;
            if (s_drd) begin
                drd_cyc = c;
                if (s_didx != v.idx) addr_ok = 1'b0;
            end
            if (s_wbv) begin
                if (wbv_cnt == 0) begin wba = s_wba; wbd = s_wbd; end
                else if (s_wba != wba || s_wbd != wbd) stable = 1'b0;
                wbv_cnt++;
            end
            wb_ready = (c >= v.wbr);
        end
        chk("tag_we", vi, 64'(we_val), 64'(v.x_we));
        chk("tag_we_cycle", vi, 64'(we_cyc), 64'(v.x_wecyc));
        chk("tag_we_count", vi, 64'(we_cnt), 64'(v.x_we != 0));
        if (v.x_we != 0) chk("tag_wdata", vi, 64'(wd), 64'(v.x_wd));
        chk("done_cycle", vi, 64'(done_cyc), 64'(v.x_done));
        chk("done_count", vi, 64'(done_cnt), 64'(1));
        chk("ready_after_done", vi, 64'(rdy_after), 64'(1));
        chk("data_rd_cycle", vi, 64'(drd_cyc), 64'(v.x_rd));
        chk("wb_valid_cycles", vi, 64'(wbv_cnt), 64'(v.x_wbv));
        chk("strobe_addr", vi, 64'(addr_ok), 64'(1));
        if (v.x_wbv != 0) begin
            chk("wb_addr", vi, 64'(wba), 64'(v.x_addr));
            chk("wb_data", vi, 64'(wbd == line_pat), 64'(1));
            chk("wb_stable", vi, 64'(stable), 64'(1));
        end
    endtask

    task automatic chk_idle(string nm);
        chk({nm, "_m"}, -1, 64'({m_busy, m_ready, m_done, m_trd, m_we, m_drd, m_wbv}), 64'(8'b0100_0000));
        chk({nm, "_n"}, -1, 64'({n_busy, n_ready, n_done, n_trd, n_we, n_drd, n_wbv}), 64'(8'b0100_0000));
    endtask

    initial begin
        //          op idx    w tag         vb db e0          e1          wbr nd  we     wecyc wd          done rd wbv addr
        vecs[0]  = '{1, 8'h3A, 1, 20'h12345, 1, 0, 22'h0,      22'h0,      0,  0, 2'b10, 1, 22'h212345, 2,  0, 0, 32'h0};
        vecs[1]  = '{3, 8'h21, 0, 20'hABCDE, 0, 0, 22'h2ABCDE, 22'h0,      0,  0, 2'b01, 3, 22'h0,      4,  0, 0, 32'h0};
        vecs[2]  = '{3, 8'h21, 0, 20'hABCDF, 0, 0, 22'h2ABCDE, 22'h0,      0,  0, 2'b00, 0, 22'h0,      3,  0, 0, 32'h0};
        vecs[3]  = '{4, 8'h10, 0, 20'h00400, 0, 0, 22'h300401, 22'h300400, 8,  0, 2'b10, 9, 22'h0,      10, 3, 4, 32'h00400100};
        vecs[4]  = '{2, 8'h20, 0, 20'h00000, 0, 0, 22'h255555, 22'h3FFFFF, 0,  0, 2'b01, 3, 22'h0,      4,  0, 0, 32'h0};
        vecs[5]  = '{0, 8'h44, 0, 20'hFFFFF, 1, 1, 22'h0,      22'h0,      0,  0, 2'b01, 1, 22'h0,      2,  0, 0, 32'h0};
        vecs[6]  = '{6, 8'h01, 0, 20'h00000, 0, 0, 22'h0,      22'h0,      0,  0, 2'b00, 0, 22'h0,      1,  0, 0, 32'h0};
        vecs[7]  = '{4, 8'h7F, 1, 20'h0F0F0, 0, 0, 22'h30F0F0, 22'h30F0F0, 0,  0, 2'b01, 6, 22'h0,      7,  3, 1, 32'h0F0F07F0};
        vecs[8]  = '{3, 8'h33, 0, 20'h12121, 0, 0, 22'h012121, 22'h312121, 0,  0, 2'b10, 3, 22'h0,      4,  0, 0, 32'h0};
        vecs[9]  = '{2, 8'h05, 1, 20'h00000, 0, 0, 22'h0,      22'h377777, 0,  1, 2'b10, 3, 22'h0,      4,  0, 0, 32'h0};
        vecs[10] = '{1, 8'h06, 0, 20'h0ABCD, 1, 1, 22'h0,      22'h0,      0,  1, 2'b01, 1, 22'h20ABCD, 2,  0, 0, 32'h0};
        vecs[11] = '{2, 8'hFF, 1, 20'h00000, 0, 0, 22'h0,      22'h33C3C3, 2,  0, 2'b10, 6, 22'h0,      7,  3, 1, 32'h3C3C3FF0};
        vecs[12] = '{7, 8'h02, 1, 20'h00000, 0, 0, 22'h0,      22'h0,      0,  0, 2'b00, 0, 22'h0,      1,  0, 0, 32'h0};
        vecs[13] = '{1, 8'h09, 1, 20'hABCDE, 1, 1, 22'h0,      22'h0,      0,  0, 2'b10, 1, 22'h3ABCDE, 2,  0, 0, 32'h0};

        reset = 1'b1; req_valid = 1'b0; req_valid_nd = 1'b0; wb_ready = 1'b0; sel_nd = 1'b0;
        req_op = '0; req_index = '0; req_way = 1'b0; req_tag = '0;
        req_valid_bit = 1'b0; req_dirty_bit = 1'b0; ent0 = '0; ent1 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("reset_state");

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Reset while parked in WB_SEND must abort without a tag write or done.
        begin
            int we_seen = 0, done_seen = 0;
            @(negedge clk);
            sel_nd = 1'b0; ent0 = 22'h0; ent1 = 22'h300400; wb_ready = 1'b0;
            req_op = 3'd4; req_index = 8'h10; req_tag = 20'h00400; req_valid = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            chk("wb_pending_before_reset", 100, 64'(m_wbv), 64'(1));
            reset = 1'b1;
            @(negedge clk);
            chk_idle("after_reset_in_wb");
            reset = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (m_we != 2'b00) we_seen++;
                if (m_done) done_seen++;
            end
            chk("no_tag_we_after_abort", 100, 64'(we_seen), 64'(0));
            chk("no_done_after_abort", 100, 64'(done_seen), 64'(0));
        end
        run_vec(vecs[0], 101);
        run_vec(vecs[3], 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_op_engine.md
# cache_op_engine

Executes MIPS CACHE maintenance operations on one 2-way set-associative cache (one instance for the D-cache, one for the I-cache). It accepts a single request carrying the fields CP0 supplies: op, index, way, tag, and the TagLo valid/dirty bits. It sequences tag-array reads and writes and, for dirty lines, a full-line writeback. It signals completion with a one-cycle `done` pulse, which releases the pipeline stall.

## Interface
- `INDEX_W`, default 8: set index width (vaddr[11:4]).
- `TAG_W`, default 20: physical tag width (paddr[31:12]).
- `LINE_W`, default 128: line data width (16-byte lines).
- `HAS_DIRTY`, default 1: 0 for the I-cache; dirty bits are written 0 and writeback ops degrade to invalidate.
- `clk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle and able to accept a request.
- `req_op` in 3: 0 Index_Invalidate, 1 Index_Store_Tag, 2 Index_Writeback_Invalidate, 3 Hit_Invalidate, 4 Hit_Writeback_Invalidate; codes 5–7 are no-ops.
- `req_index` in INDEX_W: set index.
- `req_way` in 1: way for Index ops.
- `req_tag` in TAG_W: physical tag; used for Hit compare and as the Index_Store_Tag value.
- `req_valid_bit`, `req_dirty_bit` in 1 each: TagLo V/D values for Index_Store_Tag.
- `busy` out 1: engine not idle.
- `done` out 1: one-cycle completion pulse.
- `tag_rd_en` out 1: tag read strobe.
- `tag_addr` out INDEX_W: tag array address for read and write.
- `tag_rdata0`, `tag_rdata1` in TAG_W+2: {V, D, tag} for way0/way1; valid the cycle after `tag_rd_en`.
- `tag_we` out 2: per-way write enable.
- `tag_wdata` out TAG_W+2: {V, D, tag}.
- `data_rd_en` out 1: data read strobe.
- `data_rd_way` out 1: way to read.
- `data_rd_index` out INDEX_W: set to read.
- `data_rdata` in LINE_W: line data; valid the cycle after `data_rd_en`.
- `wb_valid` out 1: writeback request valid.
- `wb_ready` in 1: writeback request accepted.
- `wb_addr` out 32: {tag, index, 4'b0}.
- `wb_data` out LINE_W: line data.

## Operation
- States: IDLE, TAG_RD, TAG_CHK, DATA_RD, DATA_LAT, WB_SEND, TAG_WR, DONE.
- `req_ready = (state==IDLE)`. Acceptance occurs on `req_valid && req_ready`; all request fields are latched on acceptance.
- Path by op:
  - Index_Invalidate and Index_Store_Tag go IDLE→TAG_WR→DONE with no read. Index_Invalidate writes 0 to way `req_way`. Index_Store_Tag writes {req_valid_bit, req_dirty_bit & HAS_DIRTY, req_tag}.
  - All other valid ops go IDLE→TAG_RD (`tag_rd_en=1`, `tag_addr=index`)→TAG_CHK.
- Victim selection in TAG_CHK:
  - Index ops use `req_way`.
  - Hit ops use the way with V=1 and tag==req_tag. If both ways match, way0 wins. If neither matches, go to DONE with no write.
- Dirty handling in TAG_CHK, for *_Writeback_Invalidate with victim V=1, D=1 and HAS_DIRTY=1:
  - Go to DATA_RD (`data_rd_en=1`), then DATA_LAT (latch `data_rdata`), then WB_SEND.
  - Otherwise go straight to TAG_WR.
- Writeback address: `wb_addr` uses the victim's stored tag, not `req_tag`.
- WB_SEND: `wb_valid=1` with `wb_addr`/`wb_data` held stable until `wb_ready`; on the handshake cycle go to TAG_WR.
- TAG_WR: `tag_we` one-hot on the victim way for exactly one cycle. Invalidate ops write {0, 0, 0}.
- DONE: `done=1` for one cycle, then IDLE.
- Op codes 5–7: IDLE→DONE.
- `busy = (state!=IDLE)`.

## Timing
- Accept in cycle A.
- Index_Invalidate / Index_Store_Tag: `tag_we` at A+1, `done` at A+2.
- Hit op, miss: `tag_rd_en` at A+1, decision at A+2, `done` at A+3, no `tag_we`.
- Read-path op with a clean or invalid victim: `tag_we` at A+3, `done` at A+4.
- Dirty writeback: `data_rd_en` at A+3, `wb_valid` rises at A+5.
  - If `wb_ready` is high at cycle W: `tag_we` at W+1, `done` at W+2.
  - `wb_ready` held high from the start gives `done` at A+7.
- Next request can be accepted the cycle after `done`.
- Reset:
  - After a cycle with `reset=1`: state=IDLE, and `busy`, `done`, `tag_rd_en`, `tag_we`, `data_rd_en`, `wb_valid` are all 0; `req_ready=1`.
  - A reset in any state, including WB_SEND, aborts the op with no tag write and no `done`.
- `tag_addr` / `data_rd_index` equal the latched index whenever the corresponding strobe is high.

## Test plan
- Index_Store_Tag, index 0x3A, way 1, V=1, D=0, tag 0x12345 → at A+1 `tag_we=2'b10`, `tag_wdata={1,0,0x12345}`; `done` at A+2.
- Hit_Invalidate, tag 0xABCDE; way0 holds {1,0,0xABCDE} → `tag_we=2'b01`, `tag_wdata=0`, `done` at A+4. Repeat with tag 0xABCDF → no `tag_we`, `done` at A+3.
- Hit_Writeback_Invalidate, index 0x10; way1 holds {1,1,0x00400}; `data_rdata=0x1111…`; `wb_ready` low for 3 cycles → `wb_valid` stays high 4 cycles with `wb_addr=0x00400100` and data stable; then `tag_we=2'b10`, `done` 2 cycles after the handshake.
- Index_Writeback_Invalidate on a clean valid line → no `data_rd_en`, no `wb_valid`; `tag_we` at A+3.
- HAS_DIRTY=0 instance, Index_Writeback_Invalidate on a line with D=1 → no writeback, line invalidated; Index_Store_Tag with D=1 writes D=0.
- Reset asserted during WB_SEND → next cycle `wb_valid=0`, `req_ready=1`, no `tag_we`, no `done`; a fresh request afterwards completes normally.
